// File: rtl/stepgen_pkg.sv
// stepgen_pkg: shared state enum, velocity word type and clamp helper for the stepgen ramp logic
package stepgen_pkg;
  typedef enum logic [1:0] {HOLD, RAMP_UP, RAMP_DOWN, WDOG_STOP} state_e;
  localparam int F_DEF = 10;
  typedef logic signed [F_DEF:0] vel_t;
  function automatic int vel_max(input int f);
    return (1 << f) - 1;
  endfunction
endpackage

// File: rtl/stepgen_velramp_tick.sv
// stepgen_velramp_tick: update-rate prescaler (tick) and watchdog tick counter (wdog_fire, only with STEPGEN_VELRAMP_WDOG_EN); ports clk, reset, enable, load, rate_div, wdog_timeout -> tick, wdog_fire
module stepgen_velramp_tick
  import stepgen_pkg::*;
#(
  parameter int P = 8,
  parameter int D = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         load,
  input  logic [P-1:0] rate_div,
  input  logic [D-1:0] wdog_timeout,
  output logic         tick,
  output logic         wdog_fire
);
  logic [P-1:0] pre_q, pre_d;
  assign tick = enable && pre_q == '0;
  always_comb begin
    pre_d = !enable ? pre_q : tick ? rate_div : pre_q - 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) pre_q <= '0;
    else pre_q <= pre_d;
  end
`ifdef STEPGEN_VELRAMP_WDOG_EN
  logic [D-1:0] wd_q, wd_d;
  logic [D:0] wd_inc;
  assign wd_inc = {1'b0, wd_q} + 1'b1;
  // a load restarts the count and suppresses a coincident fire
  assign wdog_fire = tick && !load && wdog_timeout != '0 && wd_inc >= {1'b0, wdog_timeout};
  always_comb begin
    wd_d = load ? '0 : (tick && wd_q != '1) ? wd_inc[D-1:0] : wd_q;
  end
  always_ff @(posedge clk) begin
    if (reset) wd_q <= '0;
    else wd_q <= wd_d;
  end
`else
  logic unused_ok;
  assign unused_ok = ^{load, wdog_timeout};
  assign wdog_fire = 1'b0;
`endif
endmodule

// File: rtl/stepgen_velramp.sv
// stepgen_velramp: accel-limited velocity ramp feeding stepgen velocity; ports clk, reset, enable, target/target_load, accel, rate_div, wdog_timeout -> velocity, at_speed, wdog_trip; watchdog built only with STEPGEN_VELRAMP_WDOG_EN
module stepgen_velramp
  import stepgen_pkg::*;
#(
  parameter int F = 10,
  parameter int A = 8,
  parameter int P = 8,
  parameter int D = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic signed [F:0] target,
  input  logic          target_load,
  input  logic [A-1:0]  accel,
  input  logic [P-1:0]  rate_div,
  input  logic [D-1:0]  wdog_timeout,
  output logic signed [F:0] velocity,
  output logic          at_speed,
  output logic          wdog_trip
);
  localparam int VMAX_I = vel_max(F);
  localparam logic signed [F:0] VMAX = VMAX_I[F:0];
  localparam int W = (F + 2 > A ? F + 2 : A) + 1;
  logic signed [F:0] tgt_q, tgt_d, vel_q, vel_d, eff;
  logic signed [F+1:0] diff, stp;
  logic [W-1:0] mag;
  logic trip_q, trip_d, tick, fire;
  state_e st_q, st_d;
  stepgen_velramp_tick #(.P(P), .D(D)) u_tick (
    .clk(clk), .reset(reset), .enable(enable), .load(target_load),
    .rate_div(rate_div), .wdog_timeout(wdog_timeout), .tick(tick), .wdog_fire(fire)
  );
  assign eff = trip_q ? '0 : tgt_q;
  // one extra bit so the difference of two in-range velocities cannot overflow
  assign diff = {eff[F], eff} - {vel_q[F], vel_q};
  assign mag = W'(diff[F+1] ? -diff : diff);
  // only used when accel < |diff|, so truncation to F+2 bits is lossless there
  assign stp = (F + 2)'(accel);
  always_comb begin
    tgt_d = !target_load ? tgt_q : (target[F] && target[F-1:0] == '0) ? -VMAX : target;
    vel_d = !tick ? vel_q : mag <= W'(accel) ? eff : diff[F+1] ? vel_q - stp[F:0] : vel_q + stp[F:0];
    trip_d = target_load ? 1'b0 : fire ? 1'b1 : trip_q;
  end
  always_comb begin
    st_d = (target_load && st_q == WDOG_STOP) ? HOLD :
           !tick ? st_q :
           (trip_q || fire) ? WDOG_STOP :
           diff[F+1] ? RAMP_DOWN :
           diff != '0 ? RAMP_UP : HOLD;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_q <= '0;
      vel_q <= '0;
      trip_q <= 1'b0;
      st_q <= HOLD;
    end else begin
      tgt_q <= tgt_d;
      vel_q <= vel_d;
      trip_q <= trip_d;
      st_q <= st_d;
    end
  end
  assign velocity = vel_q;
  assign at_speed = vel_q == eff;
  assign wdog_trip = trip_q;
endmodule

// File: tb/tb_stepgen_velramp.sv
// tb_stepgen_velramp: directed and random stimulus against an integer reference model of the ramp
module tb_stepgen_velramp;
  logic clk = 1'b0;
  logic reset, enable, target_load;
  logic signed [10:0] target;
  logic [7:0] accel, rate_div;
  logic [11:0] wdog_timeout;
  logic signed [10:0] velocity;
  logic at_speed, wdog_trip;
  int n_tests = 0, n_fail = 0;
  int m_tgt, m_vel, m_pc, m_wc;
  bit m_trip;
  always #5 clk = ~clk;
  stepgen_velramp dut (
    .clk(clk), .reset(reset), .enable(enable), .target(target), .target_load(target_load),
    .accel(accel), .rate_div(rate_div), .wdog_timeout(wdog_timeout),
    .velocity(velocity), .at_speed(at_speed), .wdog_trip(wdog_trip)
  );
  task automatic model();
    int eff, d, a, t;
    bit tk;
    if (reset) begin
      m_tgt = 0; m_vel = 0; m_pc = 0; m_wc = 0; m_trip = 0;
      return;
    end
    a = int'(accel);
    eff = m_trip ? 0 : m_tgt;
    tk = enable && m_pc == 0;
    if (enable) m_pc = tk ? int'(rate_div) : m_pc - 1;
    if (tk) begin
      d = eff - m_vel;
      if (d > a) m_vel += a;
      else if (d < -a) m_vel -= a;
      else m_vel = eff;
    end
`ifdef STEPGEN_VELRAMP_WDOG_EN
    if (tk) begin
      m_wc++;
      if (wdog_timeout != 0 && m_wc >= int'(wdog_timeout)) m_trip = 1;
    end
`endif
    if (target_load) begin
      t = int'(target);
      m_tgt = t < -1023 ? -1023 : t;
      m_trip = 0;
      m_wc = 0;
    end
  endtask
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    model();
    @(posedge clk);
    #1;
    chk("velocity", $signed(velocity), m_vel);
    chk("at_speed", {31'd0, at_speed}, {31'd0, m_vel == (m_trip ? 0 : m_tgt)});
    chk("wdog_trip", {31'd0, wdog_trip}, {31'd0, m_trip});
  endtask
  task automatic ticks(input int n);
    repeat (n) step();
  endtask
  task automatic load(input int v);
    target = 11'(v);
    target_load = 1'b1;
    step();
    target_load = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b1; enable = 1'b1; target_load = 1'b0; target = '0;
    accel = 8'd10; rate_div = '0; wdog_timeout = '0;
    do_reset();
    chk("rst_velocity", $signed(velocity), 0);
    chk("rst_at_speed", {31'd0, at_speed}, 1);
    chk("rst_wdog_trip", {31'd0, wdog_trip}, 0);
    load(100);
    ticks(9);
    chk("ramp_up_90", $signed(velocity), 90);
    chk("ramp_up_not_at_speed", {31'd0, at_speed}, 0);
    step();
    chk("ramp_up_100", $signed(velocity), 100);
    chk("ramp_up_at_speed", {31'd0, at_speed}, 1);
    do_reset();
    load(95);
    ticks(10);
    chk("no_overshoot_95", $signed(velocity), 95);
    ticks(3);
    chk("hold_95", $signed(velocity), 95);
    accel = 8'd20;
    load(50);
    ticks(3);
    chk("down_to_50", $signed(velocity), 50);
    load(-30);
    ticks(1);
    chk("rev_30", $signed(velocity), 30);
    ticks(2);
    chk("rev_m10", $signed(velocity), -10);
    ticks(1);
    chk("rev_m30", $signed(velocity), -30);
    accel = 8'd255;
    load(-1024);
    ticks(6);
    chk("clamp_m1023", $signed(velocity), -1023);
    accel = 8'd0;
    load(200);
    ticks(5);
    chk("accel0_frozen", $signed(velocity), -1023);
    chk("accel0_not_at_speed", {31'd0, at_speed}, 0);
    accel = 8'd10;
    rate_div = 8'd3;
    load(0);
    ticks(12);
    enable = 1'b0;
    ticks(10);
    enable = 1'b1;
    ticks(12);
    rate_div = '0;
    load(500);
    ticks(3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_ramp_reset", $signed(velocity), 0);
`ifdef STEPGEN_VELRAMP_WDOG_EN
    accel = 8'd100;
    wdog_timeout = 12'd5;
    load(100);
    ticks(4);
    chk("wdog_not_yet", {31'd0, wdog_trip}, 0);
    step();
    chk("wdog_tripped", {31'd0, wdog_trip}, 1);
    chk("wdog_hold_100", $signed(velocity), 100);
    accel = 8'd25;
    ticks(4);
    chk("wdog_stop_0", $signed(velocity), 0);
    load(40);
    chk("wdog_cleared", {31'd0, wdog_trip}, 0);
    ticks(2);
    chk("wdog_resume_40", $signed(velocity), 40);
    wdog_timeout = '0;
`endif
    for (int i = 0; i < 1500; i++) begin
      enable = $urandom_range(9) != 0;
      target_load = $urandom_range(9) == 0;
      target = 11'($urandom);
      if ($urandom_range(19) == 0) accel = 8'($urandom);
      if ($urandom_range(19) == 0) rate_div = 8'($urandom_range(3));
      if ($urandom_range(29) == 0) wdog_timeout = 12'($urandom_range(20));
      reset = $urandom_range(199) == 0;
      step();
    end
    reset = 1'b0;
    target_load = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
